// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: ALU opcodes, controlE field positions and forward-select codes
package execute_stage_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;
  localparam int CTL_REGWRITE  = 9;
  localparam int CTL_RESULTSRC = 7;
  localparam int CTL_MEMWRITE  = 6;
  localparam int CTL_JUMP      = 5;
  localparam int CTL_BRANCH    = 4;
  localparam int CTL_ALUCTL    = 1;
  localparam int CTL_ALUSRC    = 0;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/execute_stage_alu.sv
// execute_stage_alu: combinational RV32 ALU with zero flag
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctl,
  output logic [XLEN-1:0] y,
  output logic            zero
);
  always_comb begin
    y = ctl == ALU_ADD ? a + b :
        ctl == ALU_SUB ? a - b :
        ctl == ALU_AND ? a & b :
        ctl == ALU_OR  ? a | b :
        ctl == ALU_XOR ? a ^ b :
        ctl == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
        ctl == ALU_SLL ? a << b[4:0] :
                         a >> b[4:0];
  end
  assign zero = y == '0;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, branch/jump resolution and EX/MEM register
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [9:0]      controlE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [3:0]      controlM
);
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y;
  logic            zero;
  always_comb begin
    src_a = ForwardAE == FWD_WB  ? ResultW :
            ForwardAE == FWD_MEM ? ALUResultM : RD1E;
    fwd_b = ForwardBE == FWD_WB  ? ResultW :
            ForwardBE == FWD_MEM ? ALUResultM : RD2E;
    src_b = controlE[CTL_ALUSRC] ? ImmExtE : fwd_b;
  end
  execute_stage_alu #(.XLEN(XLEN)) u_alu (
    .a    (src_a),
    .b    (src_b),
    .ctl  (controlE[CTL_ALUCTL +: 3]),
    .y    (alu_y),
    .zero (zero)
  );
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = (controlE[CTL_BRANCH] & zero) | controlE[CTL_JUMP];
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
      controlM   <= '0;
    end else begin
      ALUResultM <= alu_y;
      WriteDataM <= fwd_b;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
      controlM   <= controlE[CTL_REGWRITE:CTL_MEMWRITE];
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed scoreboard bench for execute_stage
module tb_execute_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic [9:0]  controlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [3:0]  controlM;
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [3:0]  ctl;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  execute_stage dut (
    .CLK(CLK), .RST(RST), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .RdE(RdE), .controlE(controlE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .controlM(controlM)
  );
  always #5 CLK = ~CLK;
  function automatic logic [9:0] mk_ctl(input logic rw, input logic [1:0] rs, input logic mw,
                                        input logic j, input logic b, input logic [2:0] op,
                                        input logic src);
    return {rw, rs, mw, j, b, op, src};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic [9:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] rw);
    RD1E = rd1; RD2E = rd2; PCE = pc; ImmExtE = imm; PCPlus4E = pc4; RdE = rd;
    controlE = ctl; ForwardAE = fa; ForwardBE = fb; ResultW = rw;
    #1;
  endtask
  task automatic expect_m(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] pc4, input logic [3:0] ctl);
    q.push_back('{alu: alu, wd: wd, rd: rd, pc4: pc4, ctl: ctl});
  endtask
  task automatic tick(input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    n_vec++;
    assert (q.size() != 0) else begin
      n_err++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_alu"}, ALUResultM, e.alu);
      chk({tag, "_wd"}, WriteDataM, e.wd);
      chk({tag, "_rd"}, {27'd0, RdM}, {27'd0, e.rd});
      chk({tag, "_pc4"}, PCPlus4M, e.pc4);
      chk({tag, "_ctl"}, {28'd0, controlM}, {28'd0, e.ctl});
    end
  endtask
  task automatic comb(input string tag, input logic src, input logic [31:0] tgt);
    chk({tag, "_pcsrc"}, {31'd0, PCSrcE}, {31'd0, src});
    chk({tag, "_target"}, PCTargetE, tgt);
  endtask
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;
  initial begin
    RST = 1'b1;
    drive(32'd7, 32'd5, 32'h0, 32'h0, 32'h44, 5'd3, mk_ctl(1, 2'b00, 0, 0, 0, ADD, 0), 2'b00, 2'b00, 32'h0);
    expect_m(0, 0, 0, 0, 0);
    tick("rst1");
    expect_m(0, 0, 0, 0, 0);
    tick("rst2");
    RST = 1'b0;
    expect_m(32'd12, 32'd5, 5'd3, 32'h44, 4'b1000);
    tick("add");
    drive(32'd7, 32'd5, 32'h0, 32'h0, 32'h48, 5'd4, mk_ctl(1, 2'b00, 0, 0, 0, SUB, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'd2, 32'd5, 5'd4, 32'h48, 4'b1000);
    tick("sub");
    drive(32'd7, 32'd9, 32'h0, 32'h0, 32'h4c, 5'd5, mk_ctl(1, 2'b00, 0, 0, 0, SUB, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'hFFFFFFFE, 32'd9, 5'd5, 32'h4c, 4'b1000);
    tick("sub_neg");
    drive(32'd3, 32'd4, 32'h0, 32'h0, 32'h50, 5'd6, mk_ctl(1, 2'b00, 0, 0, 0, ADD, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'd7, 32'd4, 5'd6, 32'h50, 4'b1000);
    tick("fwd1");
    drive(32'd0, 32'h11, 32'h0, 32'd1, 32'h54, 5'd7, mk_ctl(1, 2'b00, 0, 0, 0, ADD, 1), 2'b10, 2'b00, 32'h0);
    expect_m(32'd8, 32'h11, 5'd7, 32'h54, 4'b1000);
    tick("fwd2");
    drive(32'd1, 32'h99, 32'h0, 32'h0, 32'h58, 5'd8, mk_ctl(0, 2'b00, 1, 0, 0, ADD, 0), 2'b00, 2'b01, 32'h55);
    expect_m(32'h56, 32'h55, 5'd8, 32'h58, 4'b0001);
    tick("fwd3");
    drive(32'h10, 32'h10, 32'h100, 32'hFFFFFFF8, 32'h104, 5'd0, mk_ctl(0, 2'b00, 0, 0, 1, SUB, 0), 2'b11, 2'b11, 32'h0);
    comb("beq_taken", 1'b1, 32'hF8);
    expect_m(32'h0, 32'h10, 5'd0, 32'h104, 4'b0000);
    tick("beq_taken");
    drive(32'h10, 32'h11, 32'h100, 32'hFFFFFFF8, 32'h104, 5'd0, mk_ctl(0, 2'b00, 0, 0, 1, SUB, 0), 2'b00, 2'b00, 32'h0);
    comb("beq_nt", 1'b0, 32'hF8);
    expect_m(32'hFFFFFFFF, 32'h11, 5'd0, 32'h104, 4'b0000);
    tick("beq_nt");
    drive(32'd0, 32'd0, 32'h20, 32'h40, 32'h24, 5'd1, mk_ctl(1, 2'b10, 0, 1, 0, ADD, 0), 2'b00, 2'b00, 32'h0);
    comb("jal", 1'b1, 32'h60);
    expect_m(32'h0, 32'h0, 5'd1, 32'h24, 4'b1100);
    tick("jal");
    drive(32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'h0, 5'd2, mk_ctl(1, 2'b00, 0, 0, 0, SLT, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'd1, 32'd1, 5'd2, 32'h0, 4'b1000);
    tick("slt");
    drive(32'd1, 32'h77, 32'h0, 32'h21, 32'h0, 5'd2, mk_ctl(1, 2'b00, 0, 0, 0, SLL, 1), 2'b00, 2'b00, 32'h0);
    expect_m(32'd2, 32'h77, 5'd2, 32'h0, 4'b1000);
    tick("sll");
    drive(32'h80000000, 32'd4, 32'h0, 32'h0, 32'h0, 5'd2, mk_ctl(1, 2'b00, 0, 0, 0, SRL, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'h08000000, 32'd4, 5'd2, 32'h0, 4'b1000);
    tick("srl");
    drive(32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 5'd9, mk_ctl(1, 2'b00, 0, 0, 0, AND_, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'hF000, 32'hFF00, 5'd9, 32'h0, 4'b1000);
    tick("and");
    drive(32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 5'd9, mk_ctl(1, 2'b00, 0, 0, 0, OR_, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'hFFF0, 32'hFF00, 5'd9, 32'h0, 4'b1000);
    tick("or");
    drive(32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 5'd9, mk_ctl(1, 2'b00, 0, 0, 0, XOR_, 0), 2'b00, 2'b00, 32'h0);
    expect_m(32'h0FF0, 32'hFF00, 5'd9, 32'h0, 4'b1000);
    tick("xor");
    drive(32'd5, 32'd5, 32'h30, 32'h8, 32'h34, 5'd10, 10'd0, 2'b00, 2'b00, 32'h0);
    comb("bubble", 1'b0, 32'h38);
    expect_m(32'd10, 32'd5, 5'd10, 32'h34, 4'b0000);
    tick("bubble");
    RST = 1'b1;
    drive(32'd1, 32'd2, 32'h20, 32'h40, 32'h24, 5'd1, mk_ctl(1, 2'b10, 0, 1, 0, ADD, 0), 2'b00, 2'b00, 32'h0);
    comb("rst_mid", 1'b1, 32'h60);
    expect_m(0, 0, 0, 0, 0);
    tick("rst_mid");
    RST = 1'b0;
    expect_m(32'd3, 32'd2, 5'd1, 32'h24, 4'b1100);
    tick("rst_rel");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
